// File: rtl/dpram_pkg.sv
// dpram_pkg: shared state encoding, lane constants and byte-lane merge helper
// for the byte-enable dual-port RAM.
package dpram_pkg;
    localparam int DW_DEF = 32;
    localparam int LANES = DW_DEF / 8;
    typedef enum logic [1:0] {RST, CLR, RUN} state_t;
    function automatic logic [7:0] byte_merge(input logic [7:0] old, input logic [7:0] nw, input logic be);
        return be ? nw : old;
    endfunction
endpackage

// File: rtl/dpram_inf_be_clr_if.sv
// dpram_inf_be_clr_if: two-port byte-enable RAM bus; master issues requests, slave is the RAM.
interface dpram_inf_be_clr_if #(parameter int AW = 8, parameter int DW = 32);
    logic ready, collision;
    logic rd_a, wr_a, vld_a;
    logic rd_b, wr_b, vld_b;
    logic [DW/8-1:0] be_a, be_b;
    logic [AW-1:0] address_a, address_b;
    logic [DW-1:0] data_a, data_b, q_a, q_b;
    modport master(
        input ready, collision, q_a, vld_a, q_b, vld_b,
        output rd_a, wr_a, be_a, address_a, data_a, rd_b, wr_b, be_b, address_b, data_b
    );
    modport slave(
        output ready, collision, q_a, vld_a, q_b, vld_b,
        input rd_a, wr_a, be_a, address_a, data_a, rd_b, wr_b, be_b, address_b, data_b
    );
endinterface

// File: rtl/dpram_core_be.sv
// dpram_core_be: bare true dual-port byte-enable array with one registered read port each.
// Callers must never enable the same lane of the same address on both ports.
module dpram_core_be import dpram_pkg::*; #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int RDW_NEW = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic rd_a,
    input  logic wr_a,
    input  logic [DW/8-1:0] be_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    output logic [DW-1:0] dout_a,
    input  logic rd_b,
    input  logic wr_b,
    input  logic [DW/8-1:0] be_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] din_b,
    output logic [DW-1:0] dout_b
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdat_a, rdat_b;
    always_ff @(posedge clock) begin
        for (int i = 0; i < DW / 8; i++) begin
            if (wr_a && be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
            if (wr_b && be_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
        end
    end
    // Same-port read-during-write optionally sees its own enabled bytes; the other port never does.
    always_comb begin
        rdat_a = '0;
        rdat_b = '0;
        for (int i = 0; i < DW / 8; i++) begin
            rdat_a[8*i +: 8] = byte_merge(mem[addr_a][8*i +: 8], din_a[8*i +: 8], RDW_NEW != 0 && wr_a && be_a[i]);
            rdat_b[8*i +: 8] = byte_merge(mem[addr_b][8*i +: 8], din_b[8*i +: 8], RDW_NEW != 0 && wr_b && be_b[i]);
        end
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            if (rd_a) dout_a <= rdat_a;
            if (rd_b) dout_b <= rdat_b;
        end
    end
endmodule

// File: rtl/dpram_inf_be_clr.sv
// dpram_inf_be_clr: dual-port byte-enable RAM with post-reset clear sequencer,
// same-address write arbitration (port A wins), optional output register and read-valid flags.
module dpram_inf_be_clr import dpram_pkg::*; #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int OUTREG = 0,
    parameter int RDW_NEW = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic clock,
    input logic reset_n,
    dpram_inf_be_clr_if.slave bus
);
    localparam int NL = DW / 8;
    state_t state;
    logic [AW-1:0] cnt, addr_a;
    logic ready, col, clearing, hit;
    logic rd_a, wr_a, rd_b, wr_b, v_a, v_b;
    logic [NL-1:0] be_a, be_b;
    logic [DW-1:0] din_a, dout_a, dout_b;
    // The clear sequencer owns port A from the first released cycle until the last word is zeroed.
    assign clearing = CLEAR_ON_RESET != 0 && reset_n && state != RUN;
    assign rd_a = ready && bus.rd_a;
    assign wr_a = clearing || (ready && bus.wr_a);
    assign be_a = clearing ? '1 : bus.be_a;
    assign addr_a = clearing ? cnt : bus.address_a;
    assign din_a = clearing ? '0 : bus.data_a;
    assign rd_b = ready && bus.rd_b;
    assign wr_b = ready && bus.wr_b;
    assign hit = wr_a && wr_b && addr_a == bus.address_b;
    assign be_b = hit ? bus.be_b & ~be_a : bus.be_b;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= RST;
            cnt <= '0;
            ready <= 1'b0;
            col <= 1'b0;
            v_a <= 1'b0;
            v_b <= 1'b0;
        end else begin
            col <= hit;
            v_a <= rd_a;
            v_b <= rd_b;
            if (clearing) begin
                cnt <= cnt + 1'b1;
                state <= &cnt ? RUN : CLR;
                ready <= &cnt;
            end else if (state == RST) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end
    dpram_core_be #(.AW(AW), .DW(DW), .RDW_NEW(RDW_NEW)) u_core (
        .clock(clock), .reset_n(reset_n),
        .rd_a(rd_a), .wr_a(wr_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
        .rd_b(rd_b), .wr_b(wr_b), .be_b(be_b), .addr_b(bus.address_b), .din_b(bus.data_b), .dout_b(dout_b)
    );
    assign bus.ready = ready;
    assign bus.collision = col;
    if (OUTREG != 0) begin : g_oreg
        logic [DW-1:0] q_a, q_b;
        logic vld_a, vld_b;
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                {q_a, q_b, vld_a, vld_b} <= '0;
            end else begin
                vld_a <= v_a;
                vld_b <= v_b;
                if (v_a) q_a <= dout_a;
                if (v_b) q_b <= dout_b;
            end
        end
        assign bus.q_a = q_a;
        assign bus.q_b = q_b;
        assign bus.vld_a = vld_a;
        assign bus.vld_b = vld_b;
    end else begin : g_direct
        assign bus.q_a = dout_a;
        assign bus.q_b = dout_b;
        assign bus.vld_a = v_a;
        assign bus.vld_b = v_b;
    end
endmodule

// File: tb/tb_dpram_inf_be_clr.sv
// tb_dpram_inf_be_clr: drives two RAM instances (OUTREG/RDW_NEW = 0 and = 1) with identical
// directed and random traffic and checks every output each cycle against a word-level model.
module tb_dpram_inf_be_clr;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;
    logic rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
    logic [3:0] be_a = 0, be_b = 0;
    logic [AW-1:0] address_a = 0, address_b = 0;
    logic [DW-1:0] data_a = 0, data_b = 0;
    logic [DW-1:0] q_a_o [2], q_b_o [2];
    logic vld_a_o [2], vld_b_o [2], ready_o [2], col_o [2];
    for (genvar g = 0; g < 2; g++) begin : g_dut
        dpram_inf_be_clr_if #(.AW(AW), .DW(DW)) bi ();
        assign bi.rd_a = rd_a;
        assign bi.wr_a = wr_a;
        assign bi.be_a = be_a;
        assign bi.address_a = address_a;
        assign bi.data_a = data_a;
        assign bi.rd_b = rd_b;
        assign bi.wr_b = wr_b;
        assign bi.be_b = be_b;
        assign bi.address_b = address_b;
        assign bi.data_b = data_b;
        assign q_a_o[g] = bi.q_a;
        assign q_b_o[g] = bi.q_b;
        assign vld_a_o[g] = bi.vld_a;
        assign vld_b_o[g] = bi.vld_b;
        assign ready_o[g] = bi.ready;
        assign col_o[g] = bi.collision;
        dpram_inf_be_clr #(.AW(AW), .DW(DW), .OUTREG(g), .RDW_NEW(g), .CLEAR_ON_RESET(1)) dut (
            .clock(clock), .reset_n(reset_n), .bus(bi.slave)
        );
    end
    // Reference model: word array, cycles of reset_n high, and per-instance pending read results.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [2][2];
    logic [DW-1:0] pq [2][2][4];
    logic pv [2][2][4];
    logic exp_col;
    int cyc = 0, hi = 0, n_chk = 0, n_fail = 0;
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [3:0] be);
        logic [DW-1:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (n & m);
    endfunction
    task automatic chk(input string tag, input int d, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, d, cyc, obs, exp);
        end
    endtask
    task automatic sched(input int d, input int p, input logic [DW-1:0] v);
        int s;
        s = (cyc + 1 + d) % 4;
        pv[d][p][s] = 1'b1;
        pq[d][p][s] = v;
    endtask
    task automatic tick();
        logic rdy;
        logic [DW-1:0] oa, ob;
        rdy = hi >= DEPTH;
        if (reset_n && rdy) begin
            oa = mem[address_a];
            ob = mem[address_b];
            for (int d = 0; d < 2; d++) begin
                if (rd_a) sched(d, 0, (d == 1 && wr_a) ? merge(oa, data_a, be_a) : oa);
                if (rd_b) sched(d, 1, (d == 1 && wr_b) ? merge(ob, data_b, be_b) : ob);
            end
            if (wr_b) mem[address_b] = merge(mem[address_b], data_b, be_b);
            if (wr_a) mem[address_a] = merge(mem[address_a], data_a, be_a);
        end
        exp_col = reset_n && rdy && wr_a && wr_b && address_a == address_b;
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            hi = 0;
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    exp_q[d][p] = '0;
                    for (int s = 0; s < 4; s++) pv[d][p][s] = 1'b0;
                end
        end else begin
            hi++;
            if (hi == DEPTH) for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        end
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            logic va, vb;
            va = pv[d][0][cyc % 4];
            vb = pv[d][1][cyc % 4];
            if (va) exp_q[d][0] = pq[d][0][cyc % 4];
            if (vb) exp_q[d][1] = pq[d][1][cyc % 4];
            pv[d][0][cyc % 4] = 1'b0;
            pv[d][1][cyc % 4] = 1'b0;
            chk("vld_a", d, DW'(vld_a_o[d]), DW'(va));
            chk("vld_b", d, DW'(vld_b_o[d]), DW'(vb));
            chk("q_a", d, q_a_o[d], exp_q[d][0]);
            chk("q_b", d, q_b_o[d], exp_q[d][1]);
            chk("ready", d, DW'(ready_o[d]), DW'(hi >= DEPTH));
            chk("collision", d, DW'(col_o[d]), DW'(exp_col));
        end
    endtask
    task automatic idle();
        {rd_a, wr_a, rd_b, wr_b, be_a, be_b} = '0;
    endtask
    task automatic rnd_ops(input int amax);
        rd_a = 1'($urandom);
        wr_a = 1'($urandom);
        rd_b = 1'($urandom);
        wr_b = 1'($urandom);
        be_a = 4'($urandom);
        be_b = 4'($urandom);
        address_a = AW'($urandom_range(0, amax));
        address_b = AW'($urandom_range(0, amax));
        data_a = $urandom;
        data_b = $urandom;
        if (wr_a && wr_b && address_a == address_b) rd_b = 1'b0;
    endtask
    task automatic wait_ready();
        int n;
        n = 0;
        while (ready_o[0] !== 1'b1 && n < 40) begin
            rnd_ops(DEPTH - 1);
            tick();
            n++;
        end
        idle();
        chk("ready_latency", 0, DW'(n), DW'(DEPTH));
    endtask
    task automatic sweep_reads();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            rd_a = 1'b1;
            address_a = AW'(i);
            rd_b = 1'b1;
            address_b = AW'(DEPTH - 1 - i);
            tick();
        end
        idle();
        repeat (3) tick();
    endtask
    initial begin
        idle();
        repeat (3) tick();
        reset_n = 1'b1;
        wait_ready();
        sweep_reads();
        // byte-lane writes
        wr_a = 1; be_a = 4'hF; address_a = 3; data_a = 32'hAABBCCDD;
        tick();
        be_a = 4'h5; data_a = 32'h11223344;
        tick();
        idle(); rd_a = 1; address_a = 3;
        tick();
        idle();
        repeat (3) tick();
        for (int d = 0; d < 2; d++) chk("be_merge", d, q_a_o[d], 32'hAA22CC44);
        // same-address collision
        wr_a = 1; be_a = 4'h3; address_a = 5; data_a = 32'h11111111;
        wr_b = 1; be_b = 4'hF; address_b = 5; data_b = 32'h22222222;
        tick();
        for (int d = 0; d < 2; d++) chk("collision_pulse", d, DW'(col_o[d]), 1);
        idle(); rd_b = 1; address_b = 5;
        tick();
        for (int d = 0; d < 2; d++) chk("collision_end", d, DW'(col_o[d]), 0);
        idle();
        repeat (3) tick();
        for (int d = 0; d < 2; d++) chk("collision_data", d, q_b_o[d], 32'h22221111);
        // read-during-write on address 7
        rd_a = 1; wr_a = 1; be_a = 4'hF; address_a = 7; data_a = 32'hFFFFFFFF;
        rd_b = 1; address_b = 7;
        tick();
        idle();
        repeat (3) tick();
        chk("rdw_same_old", 0, q_a_o[0], 32'h0);
        chk("rdw_same_new", 1, q_a_o[1], 32'hFFFFFFFF);
        for (int d = 0; d < 2; d++) chk("rdw_cross", d, q_b_o[d], 32'h0);
        // read latency 1 vs 2
        rd_a = 1; address_a = 3;
        tick();
        idle();
        chk("lat_n1", 0, DW'(vld_a_o[0]), 1);
        chk("lat_n1", 1, DW'(vld_a_o[1]), 0);
        tick();
        chk("lat_n2", 0, DW'(vld_a_o[0]), 0);
        chk("lat_n2", 1, DW'(vld_a_o[1]), 1);
        repeat (2) tick();
        // random traffic on a narrow address range to provoke collisions and RDW
        for (int i = 0; i < 300; i++) begin
            rnd_ops(i < 150 ? 3 : DEPTH - 1);
            tick();
        end
        idle();
        repeat (3) tick();
        // reset aborting the clear at counter 6
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        wait_ready();
        sweep_reads();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
